mem_loader: RTL and testbench
=============================

Name: mem_loader

Overview:
- Upstream feeder for the single-write-port memory (write port: wen/wa/din).
- Accepts a byte stream on a valid/ready handshake and assembles bytes MSB-first into WIDTH-bit words.
- Writes each completed word to consecutive memory addresses, starting at a programmable base, for a programmable word count.
- Used to load program/data images into the processor memory at run time, e.g. fed from a UART receiver.

Parameters:
- WIDTH, 8: memory cell size in bits. Must be a multiple of 8. BYTES = WIDTH/8.
- ADDR_SIZE, 10: memory address width in bits.

Ports:
- clk  input  1  system clock; all logic is on posedge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a load. Accepted only in IDLE or DONE.
- abort  input  1  synchronous cancel of the current load.
- base_addr  input  ADDR_SIZE  first write address. Sampled on an accepted start.
- word_cnt  input  ADDR_SIZE  number of words to load. Sampled on an accepted start; 0 means 2^ADDR_SIZE words.
- byte_in  input  8  stream data.
- byte_valid  input  1  byte_in is valid this cycle.
- byte_ready  output  1  the loader accepts a byte this cycle.
- mem_wen  output  1  memory write enable; connects to wen.
- mem_wa  output  ADDR_SIZE  memory write address; connects to wa.
- mem_din  output  WIDTH  memory write data; connects to din.
- busy  output  1  high in COLLECT or WRITE.
- done  output  1  high in DONE.
- cur_addr  output  ADDR_SIZE  next address to be written.

Behaviour:
- Reset (priority over everything):
  - State = IDLE.
  - byte_ready, mem_wen, busy, done = 0.
  - mem_wa, mem_din, cur_addr, internal word, byte index, remaining count = 0.
- States: IDLE, COLLECT, WRITE, DONE. All outputs are registered or decoded from state only; byte_ready does not depend combinationally on byte_valid.
- IDLE / DONE:
  - On start: addr <= base_addr; remaining <= word_cnt; byte index <= 0; go to COLLECT.
  - DONE holds done=1 until start, abort or reset.
- COLLECT:
  - byte_ready = 1. A byte is transferred when byte_valid and byte_ready are both high.
  - On each transfer: word <= {word[WIDTH-9:0], byte_in}; byte index increments.
  - On the transfer at index BYTES-1: go to WRITE and reset the index. With WIDTH=8, every byte goes straight to WRITE.
- WRITE (exactly one cycle):
  - mem_wen = 1, mem_wa = addr, mem_din = word, byte_ready = 0.
  - Next: addr <= addr+1, wrapping modulo 2^ADDR_SIZE; remaining <= remaining-1, also modulo (0-1 wraps, which implements the 2^ADDR_SIZE count).
  - If remaining was 1: go to DONE. Otherwise return to COLLECT.
- Timing:
  - Last byte of a word accepted at cycle N -> mem_wen high at cycle N+1.
  - Peak throughput is one word per BYTES+1 cycles.
- Abort:
  - In any state: go to IDLE next cycle and discard any partial word.
  - If abort coincides with WRITE, that cycle's write still occurs (mem_wen already registered); nothing is written afterwards.
  - abort has priority over start.
- Ignored inputs:
  - start in COLLECT/WRITE is ignored.
  - byte_valid outside COLLECT is ignored and no data is consumed.
- Address wrap: base_addr=2^ADDR_SIZE-1 with word_cnt=2 writes address max, then address 0.
- cur_addr always reflects addr. Other outputs hold their last values when not written.

Decomposition:
- Shared package holds:
  - The state encoding constants (IDLE=0, COLLECT=1, WRITE=2, DONE=3).
  - The BYTES = WIDTH/8 derivation.
- One natural sub-module: mem_loader_shift, a byte-to-word shift assembler with byte index and word-complete flag. The FSM, address counter and remaining counter stay in the top level.

Test Plan:
- WIDTH=32, base=0x010, cnt=2, bytes 11 22 33 44 55 66 77 88 sent back-to-back -> writes 0x11223344@0x010 and 0x55667788@0x011; done=1 after the second write; memory readback matches.
- WIDTH=8, base=0x3FF, cnt=3, bytes A1 B2 C3 -> writes A1@0x3FF, B2@0x000, C3@0x001 (wrap); cur_addr=0x002 in DONE.
- WIDTH=32 with byte_valid toggled randomly (gaps of 0-5 cycles) -> same memory image as the back-to-back case; mem_wen never high in two consecutive cycles.
- Abort after 2 of 4 bytes -> state IDLE, no mem_wen pulse. Then start with base 0x020, cnt 1, bytes DE AD BE EF -> writes 0xDEADBEEF@0x020 only.
- Reset asserted mid-COLLECT, then start pulsed while busy in a new load -> all outputs 0 after reset; the mid-load start is ignored (base unchanged, no extra words).
- WIDTH=8, ADDR_SIZE=4, cnt=0 -> exactly 16 writes covering addresses base..base+15 mod 16; done=1 after the 16th write.

Source files
------------

// File: rtl/mem_loader_pkg.sv
// Shared definitions for the mem_loader slice.
// Contents:
//   state_t      - loader FSM encoding (IDLE=0, COLLECT=1, WRITE=2, DONE=3)
//   calc_bytes   - bytes per memory word (WIDTH/8)
//   idx_width    - width of a byte index able to count 0..BYTES-1 (minimum 1)
package mem_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  function automatic int calc_bytes(input int width);
    return width / 8;
  endfunction

  function automatic int idx_width(input int bytes);
    return (bytes > 1) ? $clog2(bytes) : 1;
  endfunction

endpackage

// File: rtl/mem_loader_shift.sv
// Byte-to-word shift assembler. Bytes are packed MSB-first: the first byte of
// a word ends up in the top byte lane.
// Ports:
//   clk, reset  - clock and synchronous active-high reset
//   clear       - discard any partial word and restart at byte index 0
//   shift_en    - a byte is transferred this cycle
//   byte_in     - byte being transferred
//   next_word   - word value including byte_in (valid when shift_en is high)
//   word_done   - this transfer completes a word (byte index BYTES-1)
module mem_loader_shift
  import mem_loader_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             shift_en,
  input  logic [7:0]       byte_in,
  output logic [WIDTH-1:0] next_word,
  output logic             word_done
);

  localparam int BYTES = calc_bytes(WIDTH);
  localparam int IDX_W = idx_width(BYTES);

  logic [WIDTH-1:0] word;
  logic [IDX_W-1:0] idx;

  // A single-byte word has nothing to shift; the byte is the whole word.
  generate
    if (BYTES == 1) begin : g_single
      assign next_word = byte_in;
    end else begin : g_multi
      assign next_word = {word[WIDTH-9:0], byte_in};
    end
  endgenerate

  assign word_done = shift_en && (idx == IDX_W'(BYTES - 1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      word <= '0;
      idx  <= '0;
    end else if (shift_en) begin
      word <= next_word;
      idx  <= word_done ? '0 : idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/mem_loader.sv
// Streaming memory loader: assembles a byte stream into WIDTH-bit words and
// writes them to consecutive addresses of a single-write-port memory,
// starting at base_addr, for word_cnt words (0 = 2^ADDR_SIZE words).
// Ports:
//   clk, reset               - clock and synchronous active-high reset
//   start, abort             - begin a load (IDLE/DONE only) / cancel (any state)
//   base_addr, word_cnt      - load parameters, sampled on an accepted start
//   byte_in, byte_valid      - upstream byte stream
//   byte_ready               - loader accepts a byte this cycle
//   mem_wen, mem_wa, mem_din - memory write port
//   busy, done               - status (COLLECT/WRITE, DONE)
//   cur_addr                 - next address to be written
//   dbg_state                - current FSM state (state_t encoding)
//
// Handshake: a byte moves when byte_valid && byte_ready on a rising edge.
// byte_ready is decoded from state alone (high only in COLLECT) and never
// looks at byte_valid; the producer holds byte_in/byte_valid until it sees
// the transfer edge, and the loader never takes a byte it did not flag ready.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int ADDR_SIZE = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [ADDR_SIZE-1:0] base_addr,
  input  logic [ADDR_SIZE-1:0] word_cnt,
  input  logic [7:0]           byte_in,
  input  logic                 byte_valid,
  output logic                 byte_ready,
  output logic                 mem_wen,
  output logic [ADDR_SIZE-1:0] mem_wa,
  output logic [WIDTH-1:0]     mem_din,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_SIZE-1:0] cur_addr,
  output logic [1:0]           dbg_state
);

  state_t               state;
  logic [ADDR_SIZE-1:0] addr;
  logic [ADDR_SIZE-1:0] remaining;

  logic                 start_ok;
  logic                 shift_en;
  logic                 word_done;
  logic [WIDTH-1:0]     next_word;

  // abort outranks start, so a coincident start is not accepted.
  assign start_ok = start && !abort && ((state == ST_IDLE) || (state == ST_DONE));
  assign shift_en = byte_valid && byte_ready;

  mem_loader_shift #(
    .WIDTH (WIDTH)
  ) u_shift (
    .clk       (clk),
    .reset     (reset),
    .clear     (abort || start_ok),
    .shift_en  (shift_en),
    .byte_in   (byte_in),
    .next_word (next_word),
    .word_done (word_done)
  );

  // Status outputs are pure state decodes, so they are glitch-free and
  // change only on clock edges.
  assign byte_ready = (state == ST_COLLECT);
  assign mem_wen    = (state == ST_WRITE);
  assign busy       = (state == ST_COLLECT) || (state == ST_WRITE);
  assign done       = (state == ST_DONE);
  assign cur_addr   = addr;
  assign dbg_state  = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      addr      <= '0;
      remaining <= '0;
      mem_wa    <= '0;
      mem_din   <= '0;
    end else if (abort) begin
      // A write already in progress this cycle completes (mem_wen is a
      // state decode); nothing further is written.
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            addr      <= base_addr;
            remaining <= word_cnt;
            state     <= ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          // Capture address and data on entry to WRITE so they hold their
          // values after the write cycle.
          if (word_done) begin
            mem_wa  <= addr;
            mem_din <= next_word;
            state   <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          // Both counters wrap; remaining=0 at start therefore yields
          // 2^ADDR_SIZE words.
          addr      <= addr + ADDR_SIZE'(1);
          remaining <= remaining - ADDR_SIZE'(1);
          state     <= (remaining == ADDR_SIZE'(1)) ? ST_DONE : ST_COLLECT;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// Testbench for mem_loader. Three instances share the byte stream:
//   a: WIDTH=32, ADDR_SIZE=10   b: WIDTH=8, ADDR_SIZE=10   c: WIDTH=8, ADDR_SIZE=4
// Only one instance is loading at a time; idle ones ignore the stream.
module tb_mem_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [9:0] base_addr;
  logic [9:0] word_cnt;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       start_a, start_b, start_c;
  logic       abort_a, abort_bc;

  logic        rdy_a, wen_a, busy_a, done_a;
  logic [9:0]  wa_a, cur_a;
  logic [31:0] din_a;
  logic [1:0]  st_a;

  logic        rdy_b, wen_b, busy_b, done_b;
  logic [9:0]  wa_b, cur_b;
  logic [7:0]  din_b;
  logic [1:0]  st_b;

  logic        rdy_c, wen_c, busy_c, done_c;
  logic [3:0]  wa_c, cur_c;
  logic [7:0]  din_c;
  logic [1:0]  st_c;

  mem_loader #(.WIDTH(32), .ADDR_SIZE(10)) u_a (
    .clk(clk), .reset(reset), .start(start_a), .abort(abort_a),
    .base_addr(base_addr), .word_cnt(word_cnt),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(rdy_a),
    .mem_wen(wen_a), .mem_wa(wa_a), .mem_din(din_a),
    .busy(busy_a), .done(done_a), .cur_addr(cur_a), .dbg_state(st_a)
  );

  mem_loader #(.WIDTH(8), .ADDR_SIZE(10)) u_b (
    .clk(clk), .reset(reset), .start(start_b), .abort(abort_bc),
    .base_addr(base_addr), .word_cnt(word_cnt),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(rdy_b),
    .mem_wen(wen_b), .mem_wa(wa_b), .mem_din(din_b),
    .busy(busy_b), .done(done_b), .cur_addr(cur_b), .dbg_state(st_b)
  );

  mem_loader #(.WIDTH(8), .ADDR_SIZE(4)) u_c (
    .clk(clk), .reset(reset), .start(start_c), .abort(abort_bc),
    .base_addr(base_addr[3:0]), .word_cnt(word_cnt[3:0]),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(rdy_c),
    .mem_wen(wen_c), .mem_wa(wa_c), .mem_din(din_c),
    .busy(busy_c), .done(done_c), .cur_addr(cur_c), .dbg_state(st_c)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  logic [41:0] exp_a[$];   // {addr, data}
  logic [17:0] exp_b[$];
  logic [11:0] exp_c[$];
  logic [41:0] e_a;
  logic [17:0] e_b;
  logic [11:0] e_c;
  logic [31:0] mem_a [0:1023];
  logic        pw_a = 1'b0, pw_b = 1'b0, pw_c = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] addr);
    checks++;
    errors++;
    $display("FAIL %s: write at 0x%0h with nothing expected", name, addr);
  endtask

  // Monitor: pops and compares on every memory write, sampled on negedge.
  always @(negedge clk) begin
    if (wen_a) begin
      check("a_no_b2b_wen", 64'(pw_a), 64'd0);
      if (exp_a.size() == 0) unexpected("a_unexpected_write", 64'(wa_a));
      else begin
        e_a = exp_a.pop_front();
        check("a_wa", 64'(wa_a), 64'(e_a[41:32]));
        check("a_din", 64'(din_a), 64'(e_a[31:0]));
        mem_a[wa_a] = din_a;
      end
    end
    if (wen_b) begin
      check("b_no_b2b_wen", 64'(pw_b), 64'd0);
      if (exp_b.size() == 0) unexpected("b_unexpected_write", 64'(wa_b));
      else begin
        e_b = exp_b.pop_front();
        check("b_wa", 64'(wa_b), 64'(e_b[17:8]));
        check("b_din", 64'(din_b), 64'(e_b[7:0]));
      end
    end
    if (wen_c) begin
      check("c_no_b2b_wen", 64'(pw_c), 64'd0);
      if (exp_c.size() == 0) unexpected("c_unexpected_write", 64'(wa_c));
      else begin
        e_c = exp_c.pop_front();
        check("c_wa", 64'(wa_c), 64'(e_c[11:8]));
        check("c_din", 64'(din_c), 64'(e_c[7:0]));
      end
    end
    pw_a = wen_a;
    pw_b = wen_b;
    pw_c = wen_c;
  end

  // ---------------- driver tasks ----------------
  function automatic logic rdy_of(input int sel);
    case (sel)
      0:       return rdy_a;
      1:       return rdy_b;
      default: return rdy_c;
    endcase
  endfunction

  function automatic logic done_of(input int sel);
    case (sel)
      0:       return done_a;
      1:       return done_b;
      default: return done_c;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int sel, input logic [9:0] b, input logic [9:0] c);
    base_addr = b;
    word_cnt  = c;
    case (sel)
      0:       start_a = 1'b1;
      1:       start_b = 1'b1;
      default: start_c = 1'b1;
    endcase
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
  endtask

  // Holds the byte until a rising edge where byte_ready was high.
  task automatic send_byte(input int sel, input logic [7:0] b, input int max_gap);
    logic cur;
    bit   sent;
    sent       = 1'b0;
    byte_in    = b;
    byte_valid = 1'b1;
    for (int n = 0; n < 50 && !sent; n++) begin
      cur = rdy_of(sel);
      tick();
      if (cur) sent = 1'b1;
    end
    byte_valid = 1'b0;
    if (!sent) begin
      checks++;
      errors++;
      $display("FAIL byte_accept_timeout: byte 0x%0h not taken in 50 cycles", b);
    end
    if (max_gap > 0) repeat ($urandom_range(0, max_gap)) tick();
  endtask

  task automatic wait_done(input int sel, input int budget, input string name);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      if (done_of(sel)) seen = 1'b1;
      else tick();
    end
    check(name, 64'(seen), 64'd1);
  endtask

  logic [7:0] img [8];
  logic [7:0] dead [4];

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    img  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    dead = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    reset = 1'b1;
    base_addr = '0; word_cnt = '0; byte_in = '0; byte_valid = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    abort_a = 1'b0; abort_bc = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_a_ctl", 64'({rdy_a, wen_a, busy_a, done_a, st_a}), 64'd0);
    check("rst_a_addr", 64'({wa_a, cur_a}), 64'd0);
    check("rst_a_din", 64'(din_a), 64'd0);
    check("rst_b_all", 64'({rdy_b, wen_b, busy_b, done_b, st_b, wa_b, cur_b, din_b}), 64'd0);
    check("rst_c_all", 64'({rdy_c, wen_c, busy_c, done_c, st_c, wa_c, cur_c, din_c}), 64'd0);
    reset = 1'b0;
    tick();

    // T1: WIDTH=32 back-to-back, two words from 0x010
    exp_a.push_back({10'h010, 32'h11223344});
    exp_a.push_back({10'h011, 32'h55667788});
    do_start(0, 10'h010, 10'd2);
    check("t1_busy", 64'(busy_a), 64'd1);
    for (int i = 0; i < 4; i++) send_byte(0, img[i], 0);
    check("t1_wen_latency", 64'(wen_a), 64'd1);
    check("t1_ready_low_in_write", 64'(rdy_a), 64'd0);
    for (int i = 4; i < 8; i++) send_byte(0, img[i], 0);
    wait_done(0, 20, "t1_done");
    check("t1_cur_addr", 64'(cur_a), 64'h012);
    check("t1_mem_010", 64'(mem_a[10'h010]), 64'h11223344);
    check("t1_mem_011", 64'(mem_a[10'h011]), 64'h55667788);

    // T2: WIDTH=8 address wrap from 0x3FF
    exp_b.push_back({10'h3FF, 8'hA1});
    exp_b.push_back({10'h000, 8'hB2});
    exp_b.push_back({10'h001, 8'hC3});
    do_start(1, 10'h3FF, 10'd3);
    send_byte(1, 8'hA1, 0);
    send_byte(1, 8'hB2, 0);
    send_byte(1, 8'hC3, 0);
    wait_done(1, 20, "t2_done");
    check("t2_cur_addr", 64'(cur_b), 64'h002);

    // T3: same image as T1 with random gaps, restarted from DONE
    mem_a[10'h010] = '0;
    mem_a[10'h011] = '0;
    exp_a.push_back({10'h010, 32'h11223344});
    exp_a.push_back({10'h011, 32'h55667788});
    do_start(0, 10'h010, 10'd2);
    for (int i = 0; i < 8; i++) send_byte(0, img[i], 5);
    wait_done(0, 40, "t3_done");
    check("t3_mem_010", 64'(mem_a[10'h010]), 64'h11223344);
    check("t3_mem_011", 64'(mem_a[10'h011]), 64'h55667788);

    // T4: abort after 2 of 4 bytes, then a clean single-word load
    do_start(0, 10'h030, 10'd1);
    send_byte(0, 8'h99, 0);
    send_byte(0, 8'h98, 0);
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    check("t4_state_idle", 64'(st_a), 64'd0);
    check("t4_not_busy", 64'({busy_a, done_a}), 64'd0);
    repeat (3) tick();
    exp_a.push_back({10'h020, 32'hDEADBEEF});
    do_start(0, 10'h020, 10'd1);
    for (int i = 0; i < 4; i++) send_byte(0, dead[i], 0);
    wait_done(0, 20, "t4_done");
    check("t4_cur_addr", 64'(cur_a), 64'h021);

    // T5: reset mid-COLLECT, then a start pulse while busy is ignored
    do_start(0, 10'h040, 10'd1);
    send_byte(0, 8'hAA, 0);
    send_byte(0, 8'hBB, 0);
    reset = 1'b1;
    repeat (2) tick();
    check("t5_rst_ctl", 64'({rdy_a, wen_a, busy_a, done_a, st_a}), 64'd0);
    check("t5_rst_addr", 64'({wa_a, cur_a}), 64'd0);
    check("t5_rst_din", 64'(din_a), 64'd0);
    reset = 1'b0;
    tick();
    exp_a.push_back({10'h050, 32'h01020304});
    exp_a.push_back({10'h051, 32'h05060708});
    do_start(0, 10'h050, 10'd2);
    send_byte(0, 8'h01, 0);
    send_byte(0, 8'h02, 0);
    do_start(0, 10'h060, 10'd5);
    check("t5_busy_after_ignored_start", 64'(busy_a), 64'd1);
    for (int i = 3; i <= 8; i++) send_byte(0, 8'(i), 0);
    wait_done(0, 20, "t5_done");
    check("t5_cur_addr", 64'(cur_a), 64'h052);

    // T6: ADDR_SIZE=4, word_cnt=0 -> 16 words wrapping from base 5
    for (int i = 0; i < 16; i++) exp_c.push_back({4'(i + 5), 8'(i * 7 + 1)});
    do_start(2, 10'h005, 10'd0);
    for (int i = 0; i < 16; i++) begin
      check("t6_not_done_early", 64'(done_c), 64'd0);
      send_byte(2, 8'(i * 7 + 1), 0);
    end
    wait_done(2, 10, "t6_done");
    check("t6_cur_addr", 64'(cur_c), 64'h5);

    repeat (5) tick();
    check("drain_a", 64'(exp_a.size()), 64'd0);
    check("drain_b", 64'(exp_b.size()), 64'd0);
    check("drain_c", 64'(exp_c.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
